tile_line_fetcher: RTL
======================

# tile_line_fetcher

Parametrised background tile fetcher for the VGA path. It is the next generation of the single-layout tile engine, with configurable tile geometry, map count and pixel depth. Once per scanline it walks the selected tilemap row and looks up each tile's pattern row through external synchronous ROMs. It then emits one tile-row word per column to the line-buffer writer, adding vertical scroll with wrap-around and per-tile horizontal/vertical flip.

## Interface
Parameters:
- TILE_W, 16: tile width in pixels
- TILE_H, 16: tile height in lines; power of two
- BPP, 16: bits per pixel
- COLS, 40: tiles per line
- ROWS, 30: tile rows per map
- MAPS, 4: number of tilemaps
- ID_W, 8: tile id width
- V_ACTIVE, 480: visible lines
- V_TOTAL, 525: total lines per frame

Derived values:
- MAP_AW = clog2(MAPS*COLS*ROWS)
- PAT_AW = ID_W + clog2(TILE_H)
- PIX_H = ROWS*TILE_H

Ports:
- clk, in, 1: clock
- reset, in, 1: reset, synchronous, active-high
- line_start, in, 1: one-cycle pulse at start of horizontal blank
- vcount, in, 10: current line number
- map_sel, in, clog2(MAPS): tilemap select; sampled at line_start
- scroll_y, in, clog2(PIX_H): vertical scroll in lines; sampled at line_start
- map_addr, out, MAP_AW: tilemap ROM address; registered
- map_q, in, ID_W+2: entry read from map ROM; valid 1 cycle after address. Layout: [ID_W-1:0] id, [ID_W] hflip, [ID_W+1] vflip
- pat_addr, out, PAT_AW: pattern ROM address
- pat_q, in, TILE_W*BPP: pattern row; valid 1 cycle after address. Pixel 0 is in the MSBs
- out_valid, out, 1: out_col/out_data valid this cycle
- out_col, out, clog2(COLS): column index of out_data
- out_data, out, TILE_W*BPP: tile-row pixels, flip applied
- done, out, 1: idle; no fetch in progress

## Operation
- Two states: IDLE (done=1) and FETCH (done=0).
- At line_start, the target line is decided from vcount:
  - vcount < V_ACTIVE-1: target = vcount+1.
  - vcount == V_TOTAL-1: target = 0.
  - Any other value: no fetch; stay in or enter IDLE.
- Source line y = target + scroll_y. If y ≥ PIX_H, subtract PIX_H (wrap-around). scroll_y ≥ PIX_H is illegal input.
- map_sel ≥ MAPS is clamped to MAPS-1.
- Map address: map_addr = map_sel*COLS*ROWS + (y/TILE_H)*COLS + c, for c = 0..COLS-1 in order.
- Fine row: fy = y mod TILE_H. If the entry's vflip=1, fy becomes TILE_H-1-fy.
- Pattern address: pat_addr = id*TILE_H + fy. It is combinational from map_q plus the registered fine row.
- Output data: if the entry's hflip=1, the pixel order of pat_q is reversed (BPP-bit pixel groups swapped end to end); otherwise pat_q is passed through. The hflip bit is delayed one stage to align with pat_q.
- line_start while in FETCH aborts the current line: pipeline valid bits are cleared and the new line starts. No out_valid from the aborted line appears after the restart.
- All address arithmetic is unsigned at full derived width, with no truncation before the final add.

## Timing
- Let t0 be the cycle in which line_start is sampled high.
- map_addr for column c is driven at t0+1+c.
- map_q for column c arrives at t0+2+c. pat_addr is valid in that same cycle.
- pat_q for column c arrives at t0+3+c.
- out_valid/out_col/out_data for column c are registered at t0+4+c.
- Latency from line_start to column 0 is 4 cycles; output is one column per cycle with no gaps.
- done falls at t0+1. It rises at t0+COLS+4, the cycle after the last out_valid.
- A line occupies COLS+4 cycles and must fit within horizontal blank.
- Reset values:
  - done=1
  - out_valid=0, out_col=0, out_data=0
  - map_addr=0, pat_addr=0
  - all pipeline valid bits 0
- Reset mid-line drops all in-flight columns immediately.
- line_start and reset in the same cycle: reset wins.

## Test plan
- Defaults, vcount=9, map_sel=1, scroll_y=0:
  - map_addr sequence is 1200+0*40+0 .. 1239 (line 10 → row 0, fy=10).
  - pat_addr = id*16+10.
  - out_valid is high from t0+4 to t0+43; done rises at t0+44.
- vcount=524: fetches line 0 (map_addr 0..39 for map 0). vcount=500: no fetch; done stays 1 and out_valid stays 0.
- scroll_y=470, vcount=9: y = 480 → wraps to 0. Row 0 is fetched with fy=0.
- Entry with vflip=1 and hflip=1, fy=3: pat_addr = id*16+12, and out_data has pixel 0 equal to pat_q pixel 15.
- line_start re-pulsed at t0+10 of a line: exactly 40 out_valid pulses follow the restart, cols 0..39. No stale column appears.
- reset asserted at t0+20: the next cycle has done=1 and out_valid=0. A subsequent line_start fetches normally.

Source files
------------

// File: rtl/tile_line_fetcher.sv
// Background tile fetcher: once per scanline walks one tilemap row
// through external map/pattern ROMs and emits flipped tile-row words.
module tile_line_fetcher #(
  parameter int TILE_W   = 16,
  parameter int TILE_H   = 16,
  parameter int BPP      = 16,
  parameter int COLS     = 40,
  parameter int ROWS     = 30,
  parameter int MAPS     = 4,
  parameter int ID_W     = 8,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  localparam int MAP_AW  = $clog2(MAPS*COLS*ROWS),
  localparam int FY_W    = $clog2(TILE_H),
  localparam int PAT_AW  = ID_W + FY_W,
  localparam int PIX_H   = ROWS*TILE_H,
  localparam int SEL_W   = (MAPS > 1) ? $clog2(MAPS) : 1,
  localparam int SY_W    = (PIX_H > 1) ? $clog2(PIX_H) : 1,
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int LW      = TILE_W*BPP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [9:0]        vcount,
  input  logic [SEL_W-1:0]  map_sel,
  input  logic [SY_W-1:0]   scroll_y,
  output logic [MAP_AW-1:0] map_addr,
  input  logic [ID_W+1:0]   map_q,
  output logic [PAT_AW-1:0] pat_addr,
  input  logic [LW-1:0]     pat_q,
  output logic              out_valid,
  output logic [COL_W-1:0]  out_col,
  output logic [LW-1:0]     out_data,
  output logic              done
);

  localparam int YW = ((SY_W > 10) ? SY_W : 10) + 1;
  localparam logic [COL_W-1:0] LAST = COL_W'(COLS-1);

  typedef enum logic {IDLE, FETCH} state_e;

  state_e state_q, state_d;

  logic [MAP_AW-1:0] ma_q, ma_d;
  logic [COL_W-1:0]  c1_q, c1_d;
  logic              v1_q, v1_d;
  logic [FY_W-1:0]   fy_q, fy_d;
  logic [COL_W-1:0]  c2_q, c2_d;
  logic              v2_q, v2_d;
  logic [COL_W-1:0]  c3_q, c3_d;
  logic              v3_q, v3_d;
  logic              h3_q, h3_d;
  logic              ov_q, ov_d;
  logic [COL_W-1:0]  oc_q, oc_d;
  logic [LW-1:0]     od_q, od_d;

  logic              go;
  logic [9:0]        tgt;
  logic [YW-1:0]     y_sum;
  logic [YW-1:0]     y_w;
  logic [SEL_W-1:0]  sel_w;
  logic [MAP_AW-1:0] start_addr;
  logic [FY_W-1:0]   start_fy;
  logic [FY_W-1:0]   fy_eff;
  logic [LW-1:0]     rev;
  logic [LW-1:0]     flip;

  // Decide target line, wrapped source line and first map address
  always_comb begin
    go  = 1'b0;
    tgt = '0;
    unique case (1'b1)
      (vcount < 10'(V_ACTIVE-1)): begin
        go  = 1'b1;
        tgt = vcount + 10'd1;
      end
      (vcount == 10'(V_TOTAL-1)): begin
        go  = 1'b1;
        tgt = '0;
      end
      default: ;
    endcase
    y_sum = YW'(tgt) + YW'(scroll_y);
    if (y_sum >= YW'(PIX_H))
      y_w = y_sum - YW'(PIX_H);
    else
      y_w = y_sum;
    if (32'(map_sel) > 32'(MAPS-1))
      sel_w = SEL_W'(MAPS-1);
    else
      sel_w = map_sel;
    start_addr = MAP_AW'(sel_w) * MAP_AW'(COLS*ROWS)
               + MAP_AW'(y_w >> FY_W) * MAP_AW'(COLS);
    start_fy = y_w[FY_W-1:0];
  end

  // Pattern address from the map entry and the line's fine row
  always_comb begin
    fy_eff   = map_q[ID_W+1] ? ~fy_q : fy_q;
    pat_addr = v2_q ? {map_q[ID_W-1:0], fy_eff} : '0;
  end

  // Horizontal flip: reverse BPP-wide pixel groups
  always_comb begin
    rev = '0;
    for (int i = 0; i < TILE_W; i++)
      rev[i*BPP +: BPP] = pat_q[(TILE_W-1-i)*BPP +: BPP];
    flip = h3_q ? rev : pat_q;
  end

  // Line state: idle until a fetchable line_start, back after last column
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (line_start && go)
          state_d = FETCH;
      end
      FETCH: begin
        if (line_start)
          state_d = go ? FETCH : IDLE;
        else if (ov_q && oc_q == LAST)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pipeline next state; line_start flushes and restarts it
  always_comb begin
    ma_d = ma_q;
    c1_d = c1_q;
    fy_d = fy_q;
    v1_d = v1_q && (c1_q != LAST);
    if (v1_q && c1_q != LAST) begin
      ma_d = ma_q + MAP_AW'(1);
      c1_d = c1_q + COL_W'(1);
    end
    v2_d = v1_q;
    c2_d = c1_q;
    v3_d = v2_q;
    c3_d = c2_q;
    h3_d = v2_q ? map_q[ID_W] : 1'b0;
    ov_d = v3_q;
    oc_d = v3_q ? c3_q : oc_q;
    od_d = v3_q ? flip : od_q;
    if (line_start) begin
      v1_d = go;
      v2_d = 1'b0;
      v3_d = 1'b0;
      ov_d = 1'b0;
      if (go) begin
        ma_d = start_addr;
        c1_d = '0;
        fy_d = start_fy;
      end
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ma_q    <= '0;
      c1_q    <= '0;
      v1_q    <= 1'b0;
      fy_q    <= '0;
      c2_q    <= '0;
      v2_q    <= 1'b0;
      c3_q    <= '0;
      v3_q    <= 1'b0;
      h3_q    <= 1'b0;
      ov_q    <= 1'b0;
      oc_q    <= '0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      c1_q    <= c1_d;
      v1_q    <= v1_d;
      fy_q    <= fy_d;
      c2_q    <= c2_d;
      v2_q    <= v2_d;
      c3_q    <= c3_d;
      v3_q    <= v3_d;
      h3_q    <= h3_d;
      ov_q    <= ov_d;
      oc_q    <= oc_d;
      od_q    <= od_d;
    end
  end

  assign map_addr  = ma_q;
  assign out_valid = ov_q;
  assign out_col   = oc_q;
  assign out_data  = od_q;
  assign done      = (state_q == IDLE);

endmodule
